// File: rtl/mlp_seq_ctrl_if.sv
// Handshake bundle between the MLP sequencer and its producer/consumer.
interface mlp_seq_ctrl_if;
    logic [15:0] inp;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        sat_flag;

    modport master (
        output inp, in_valid, out_ready,
        input  in_ready, out, out_valid, busy, sat_flag
    );

    modport slave (
        input  inp, in_valid, out_ready,
        output in_ready, out, out_valid, busy, sat_flag
    );
endinterface

// File: rtl/mlp_seq_ctrl.sv
// Sequential 4-3-3 MLP classifier: one shared signed MAC, one product per cycle,
// ReLU/saturate hidden layer, ReLU output layer and argmax.
module mlp_seq_ctrl #(
    parameter logic [95:0] W0 = {8'hE0, 8'hFC, 8'h00, 8'hE0,
                                 8'hC0, 8'hC0, 8'h40, 8'h40,
                                 8'hC0, 8'hC0, 8'h40, 8'h40},
    parameter logic [47:0] B0 = {16'hFE00, 16'h0400, 16'h0010},
    parameter logic [71:0] W1 = {8'h20, 8'hC0, 8'h40,
                                 8'h00, 8'h40, 8'h10,
                                 8'h20, 8'h20, 8'hE0},
    parameter logic [47:0] B1 = {16'h1000, 16'hF000, 16'hF000}
) (
    input logic           clk,
    input logic           rst_n,
    mlp_seq_ctrl_if.slave bus
);
    localparam int unsigned XW = 4;
    localparam int unsigned HW = 8;
    localparam int unsigned OW = 17;
    localparam int unsigned AW = 18;
    localparam int unsigned WW = 8;
    localparam int unsigned BW = 16;
    localparam int unsigned PW = WW + HW + 1;

    typedef enum logic [2:0] {IDLE, L0, L1, ARG, DONE} state_t;

    state_t                state, state_nxt;
    logic [15:0]           x_q, x_nxt;
    logic signed [AW-1:0]  acc_q, acc_nxt;
    logic [2:0][HW-1:0]    h_q, h_nxt;
    logic [2:0][OW-1:0]    o_q, o_nxt;
    logic [1:0]            oc_q, oc_nxt;
    logic [1:0]            ic_q, ic_nxt;
    logic [1:0]            out_q, out_nxt;
    logic                  out_valid_q, out_valid_nxt;
    logic                  sat_q, sat_nxt;
    logic                  in_ready_q, in_ready_nxt;
    logic                  busy_q, busy_nxt;

    logic [3:0]            w_idx;
    logic signed [WW-1:0]  w_sel;
    logic signed [BW-1:0]  b_sel;
    logic signed [HW:0]    opnd;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  sum;
    logic signed [AW-1:0]  sum_sh;
    logic [HW-1:0]         h_val;
    logic                  h_sat;
    logic [OW-1:0]         o_val;
    logic [1:0]            best;
    logic [OW-1:0]         best_val;

    // Operand selection for the shared MAC; oc is the outer (neuron) index, ic the inner one.
    always_comb begin
        if (state == L1) begin
            w_idx = 4'(3 * oc_q + ic_q);
            w_sel = W1[8*w_idx +: 8];
            b_sel = B1[16*oc_q +: 16];
            opnd  = {1'b0, h_q[ic_q]};
        end else begin
            w_idx = {oc_q, ic_q};
            w_sel = W0[8*w_idx +: 8];
            b_sel = B0[16*oc_q +: 16];
            opnd  = {5'b0, x_q[XW*ic_q +: XW]};
        end
        prod   = w_sel * opnd;
        sum    = ((ic_q == 2'd0) ? AW'(b_sel) : acc_q) + AW'(prod);
        sum_sh = sum >>> 4;
    end

    // Hidden activation: ReLU then clamp of the scaled sum; output activation: plain ReLU.
    always_comb begin
        h_sat = 1'b0;
        h_val = '0;
        if (!sum[AW-1]) begin
            if (sum_sh > AW'(255)) begin
                h_sat = 1'b1;
                h_val = 8'hFF;
            end else begin
                h_val = sum_sh[HW-1:0];
            end
        end
        o_val = sum[AW-1] ? '0 : sum[OW-1:0];
    end

    // Argmax with ties resolved toward the lowest index.
    always_comb begin
        best     = 2'd0;
        best_val = o_q[0];
        if (o_q[1] > best_val) begin
            best     = 2'd1;
            best_val = o_q[1];
        end
        if (o_q[2] > best_val) begin
            best     = 2'd2;
            best_val = o_q[2];
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_nxt     = state;
        x_nxt         = x_q;
        acc_nxt       = acc_q;
        h_nxt         = h_q;
        o_nxt         = o_q;
        oc_nxt        = oc_q;
        ic_nxt        = ic_q;
        out_nxt       = out_q;
        out_valid_nxt = out_valid_q;
        sat_nxt       = sat_q;

        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    x_nxt     = bus.inp;
                    sat_nxt   = 1'b0;
                    oc_nxt    = 2'd0;
                    ic_nxt    = 2'd0;
                    state_nxt = L0;
                end
            end
            L0: begin
                acc_nxt = sum;
                if (ic_q == 2'd3) begin
                    h_nxt[oc_q] = h_val;
                    if (h_sat) sat_nxt = 1'b1;
                    ic_nxt = 2'd0;
                    if (oc_q == 2'd2) begin
                        oc_nxt    = 2'd0;
                        state_nxt = L1;
                    end else begin
                        oc_nxt = 2'(oc_q + 2'd1);
                    end
                end else begin
                    ic_nxt = 2'(ic_q + 2'd1);
                end
            end
            L1: begin
                acc_nxt = sum;
                if (ic_q == 2'd2) begin
                    o_nxt[oc_q] = o_val;
                    ic_nxt      = 2'd0;
                    if (oc_q == 2'd2) begin
                        oc_nxt    = 2'd0;
                        state_nxt = ARG;
                    end else begin
                        oc_nxt = 2'(oc_q + 2'd1);
                    end
                end else begin
                    ic_nxt = 2'(ic_q + 2'd1);
                end
            end
            ARG: begin
                out_nxt       = best;
                out_valid_nxt = 1'b1;
                state_nxt     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        in_ready_nxt = (state_nxt == IDLE);
        busy_nxt     = (state_nxt == L0) || (state_nxt == L1) || (state_nxt == ARG);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x_q         <= '0;
            acc_q       <= '0;
            h_q         <= '0;
            o_q         <= '0;
            oc_q        <= '0;
            ic_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            x_q         <= x_nxt;
            acc_q       <= acc_nxt;
            h_q         <= h_nxt;
            o_q         <= o_nxt;
            oc_q        <= oc_nxt;
            ic_q        <= ic_nxt;
            out_q       <= out_nxt;
            out_valid_q <= out_valid_nxt;
            sat_q       <= sat_nxt;
            in_ready_q  <= in_ready_nxt;
            busy_q      <= busy_nxt;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Scoreboard bench: three parameterisations driven in lockstep, results checked by a monitor.
module tb_mlp_seq_ctrl;
    localparam logic [95:0] W0_S = {8'hE0, 8'hFC, 8'h00, 8'hE0,
                                    8'hC0, 8'hC0, 8'h40, 8'h40,
                                    8'h80, 8'h80, 8'h80, 8'h80};
    localparam logic [47:0] B0_S = {16'hFE00, 16'h0400, 16'h1F40};
    localparam int LAT = 22;

    typedef struct {
        logic [15:0] v;
        logic [1:0]  od, oz, os;
        logic        sd, sz, ss;
    } vec_t;

    typedef struct {
        logic [1:0] od, oz, os;
        logic       sd, sz, ss;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] inp = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    vec_t        tbl[7];

    mlp_seq_ctrl_if bus_d();
    mlp_seq_ctrl_if bus_z();
    mlp_seq_ctrl_if bus_s();

    assign bus_d.inp = inp;  assign bus_d.in_valid = in_valid;  assign bus_d.out_ready = out_ready;
    assign bus_z.inp = inp;  assign bus_z.in_valid = in_valid;  assign bus_z.out_ready = out_ready;
    assign bus_s.inp = inp;  assign bus_s.in_valid = in_valid;  assign bus_s.out_ready = out_ready;

    mlp_seq_ctrl dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));
    mlp_seq_ctrl #(.W1('0), .B1('0)) dut_z (.clk(clk), .rst_n(rst_n), .bus(bus_z));
    mlp_seq_ctrl #(.W0(W0_S), .B0(B0_S)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] v, input logic [1:0] od, input logic sd,
                                input logic [1:0] oz, input logic sz,
                                input logic [1:0] os, input logic ss);
        vec_t t;
        t.v = v; t.od = od; t.sd = sd; t.oz = oz; t.sz = sz; t.os = os; t.ss = ss;
        return t;
    endfunction

    function automatic exp_t mk_exp(input vec_t t, input int c);
        exp_t e;
        e.od = t.od; e.sd = t.sd; e.oz = t.oz; e.sz = t.sz; e.os = t.os; e.ss = t.ss;
        e.cyc = c;
        return e;
    endfunction

    // Present a vector, wait for acceptance and record the expected result and its edge.
    task automatic issue(input vec_t t);
        int n = 0;
        @(negedge clk);
        inp = t.v;
        in_valid = 1'b1;
        while (!bus_d.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus_d.in_ready) chk("accept_timeout", 0, 1);
        q.push_back(mk_exp(t, cyc + 1 + LAT));
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_after_accept", bus_d.busy, 1);
        chk("in_ready_after_accept", bus_d.in_ready, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("result_timeout", q.size(), 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready_d", bus_d.in_ready, 1);  chk("rst_in_ready_z", bus_z.in_ready, 1);
        chk("rst_in_ready_s", bus_s.in_ready, 1);
        chk("rst_out_valid_d", bus_d.out_valid, 0); chk("rst_out_valid_z", bus_z.out_valid, 0);
        chk("rst_out_valid_s", bus_s.out_valid, 0);
        chk("rst_busy_d", bus_d.busy, 0);  chk("rst_busy_z", bus_z.busy, 0);
        chk("rst_busy_s", bus_s.busy, 0);
        chk("rst_sat_d", bus_d.sat_flag, 0); chk("rst_sat_z", bus_z.sat_flag, 0);
        chk("rst_sat_s", bus_s.sat_flag, 0);
        chk("rst_out_d", bus_d.out, 0);  chk("rst_out_z", bus_z.out, 0);
        chk("rst_out_s", bus_s.out, 0);
    endtask

    // Monitor: pop on each rising out_valid, then insist the result stays put while held.
    exp_t cur;
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (bus_d.out_valid && !ov_prev) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk("latency", cyc, cur.cyc);
                    chk("out_d", bus_d.out, cur.od);  chk("sat_d", bus_d.sat_flag, cur.sd);
                    chk("valid_z", bus_z.out_valid, 1);
                    chk("out_z", bus_z.out, cur.oz);  chk("sat_z", bus_z.sat_flag, cur.sz);
                    chk("valid_s", bus_s.out_valid, 1);
                    chk("out_s", bus_s.out, cur.os);  chk("sat_s", bus_s.sat_flag, cur.ss);
                end
            end else if (bus_d.out_valid) begin
                chk("hold_out_d", bus_d.out, cur.od);
                chk("hold_sat_s", bus_s.sat_flag, cur.ss);
                chk("hold_out_s", bus_s.out, cur.os);
            end
            ov_prev = bus_d.out_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0] = mk(16'h00FF, 2'd1, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1);
        tbl[1] = mk(16'hFFFF, 2'd2, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0);
        tbl[2] = mk(16'hFF00, 2'd2, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1);
        tbl[3] = mk(16'h0000, 2'd2, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1);
        tbl[4] = mk(16'h000F, 2'd1, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1);
        tbl[5] = mk(16'h0031, 2'd1, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1);
        tbl[6] = mk(16'hFFFF, 2'd2, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0);

        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            issue(tbl[k]);
            drain();
        end

        // Consumer stalls in DONE while a new request is already pending.
        out_ready = 1'b0;
        issue(tbl[0]);
        n = 0;
        while (!bus_d.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", bus_d.out_valid, 1);
        inp = tbl[2].v;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_valid", bus_d.out_valid, 1);
            chk("hold_in_ready", bus_d.in_ready, 0);
            chk("hold_busy", bus_d.busy, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", bus_d.out_valid, 0);
        chk("release_in_ready", bus_d.in_ready, 1);
        chk("release_out_kept", bus_d.out, 1);
        q.push_back(mk_exp(tbl[2], cyc + 1 + LAT));
        @(negedge clk);
        chk("next_accept_busy", bus_d.busy, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Abort an inference partway through the hidden layer.
        issue(tbl[0]);
        repeat (9) @(negedge clk);
        chk("mid_l0_busy", bus_d.busy, 1);
        chk("mid_l0_sat_s", bus_s.sat_flag, 1);
        rst_n = 1'b0;
        #1 chk_reset_vals();
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(tbl[0]);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mlp_seq_ctrl.md
MLP_SEQ_CTRL -- requirements
Module: mlp_seq_ctrl

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-low: clk, rst_n.
REQ-002 Parameter W0, default {64,64,-64,-64, 64,64,-64,-64, -32,0,-4,-32}: layer-0 weights; 12 x 8-bit signed; entry 4*j+i at bits [8k+7:8k]; j = hidden neuron, i = input.
REQ-003 Parameter B0, default {16,1024,-512}: layer-0 biases in accumulator units; 3 x 16-bit signed; entry j at [16j+15:16j].
REQ-004 Parameter W1, default {-32,32,32, 16,64,0, 64,-64,32}: layer-1 weights; 9 x 8-bit signed; entry 3*k+j; k = output neuron, j = hidden.
REQ-005 Parameter B1, default {-4096,-4096,4096}: layer-1 biases; 3 x 16-bit signed.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 inp  input  16  feature vector; x_i = inp[4i+3:4i], unsigned, i=0..3.
REQ-009 in_valid  input  1  inp is valid.
REQ-010 in_ready  output  1  high exactly when state is IDLE.
REQ-011 out  output  2  class index 0..2.
REQ-012 out_valid  output  1  out and sat_flag are valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 busy  output  1  high in L0, L1, ARG.
REQ-015 sat_flag  output  1  a hidden value saturated during this inference.

Function
REQ-016 FSM states SHALL be IDLE, L0, L1, ARG, DONE; one shared signed multiply-accumulate, one product per cycle.
REQ-017 Accept SHALL occur on an edge with in_valid&in_ready: capture inp, clear sat_flag, go to L0 with j=0, i=0; in_valid outside IDLE is ignored.
REQ-018 L0: one edge per (j,i), i inner, j outer, 12 edges; at i=0 acc <= B0[j] + W0[4j+i]*x_i, else acc <= acc + W0[4j+i]*x_i.
REQ-019 Accumulator SHALL be 18-bit signed, exact, never overflowing for any parameter values.
REQ-020 On the i=3 edge h_j SHALL be written from final sum s: 0 if s<0, else min(255, s>>4); sat_flag set if s>>4 > 255.
REQ-021 After the 12th L0 edge the state SHALL go to L1: 9 edges over (k,j), same accumulate rule with B1[k], W1[3k+j], h_j.
REQ-022 On the j=2 edge o_k SHALL be stored as 17-bit unsigned relu(s), without truncation.
REQ-023 After the 9th L1 edge the state SHALL go to ARG; the ARG edge registers out = argmax(o_0,o_1,o_2) over full 17-bit values, ties to lowest index, sets out_valid, and enters DONE.
REQ-024 Latency SHALL be exactly 22 edges from the accept edge to the edge that raises out_valid.
REQ-025 DONE SHALL hold out, sat_flag, out_valid stable until an edge with out_ready high, then clear out_valid and go to IDLE; a new accept is possible from the following edge.
REQ-026 out SHALL hold its last value after out_valid drops, until the next ARG edge.

Reset
REQ-027 While rst_n is low, independent of clk: state=IDLE, out=0, out_valid=0, busy=0, sat_flag=0, in_ready=1, and acc, h_j, o_k, counters =0.
REQ-028 Reset asserted mid-inference SHALL abort it with no out_valid pulse; the first accept after release SHALL behave as from power-up.

Verification
REQ-029 inp=16'h00FF (x=15,15,0,0) -> h={121,184,0}, o={0,9616,64}; out=1 exactly 22 edges after accept; sat_flag=0.
REQ-030 inp=16'hFF00 -> h={0,0,0}, o={0,0,4096}, out=2; then inp=16'h0000 -> h={1,64,0}, o={0,16,64}, out=2.
REQ-031 Override W1=0, B1=0 -> o all 0 -> out=0 (tie to lowest index).
REQ-032 Override B0[0]=8000, inp=16'h00FF -> h_0=255, sat_flag=1; next default-range inference -> sat_flag=0.
REQ-033 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> out stable, in_ready=0, no accept; out_ready pulse -> IDLE, then accept on the next edge.
REQ-034 Assert rst_n low at edge 10 of L0 -> outputs at reset values immediately; after release, inp=16'h00FF -> out=1 after 22 edges.
